// File: rtl/main_game.sv
// main_game: six-colour, four-slot code-breaking game with VGA output.
//
// Ports
//   CLK0                system clock, all logic on its rising edge
//   RST_N               asynchronous active-low reset
//   BTN_RAW_LEFT/DOWN/RIGHT/UP/ENTER/DEBUG  raw active-high push buttons
//   LED0..LED3          hint LEDs (LEDk lit when k < exact matches; all lit on a win)
//   VGA_R/G/B           1-bit pixel colour
//   VGA_HSYNC/VSYNC     active-low 640x480 sync pulses
//
// Parameters
//   DEBOUNCE_CYCLES     stable samples required before a button level is accepted
//   MAX_GUESSES         checks allowed before the game is lost
//   PIX_DIV             clock cycles per VGA pixel
//
// Build option
//   MAIN_GAME_DEBUG_EN  when defined, holding DEBUG during play shows the secret
//                       in the lower screen band; otherwise DEBUG is ignored.
module main_game #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_GUESSES     = 10,
  parameter int PIX_DIV         = 2
) (
  input  logic CLK0,
  input  logic RST_N,
  input  logic BTN_RAW_LEFT,
  input  logic BTN_RAW_DOWN,
  input  logic BTN_RAW_RIGHT,
  input  logic BTN_RAW_UP,
  input  logic BTN_RAW_ENTER,
  input  logic BTN_RAW_DEBUG,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic VGA_R,
  output logic VGA_G,
  output logic VGA_B,
  output logic VGA_HSYNC,
  output logic VGA_VSYNC
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN   = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

`ifdef MAIN_GAME_DEBUG_EN
  localparam int N_BTN = 6;
`else
  localparam int N_BTN = 5;
`endif

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GC_W  = $clog2(MAX_GUESSES + 1);
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GC_W-1:0]  GC_MAX   = GC_W'(MAX_GUESSES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_SYNC_B = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_SPLIT  = 10'd240;
  localparam logic [9:0] V_CURSOR = 10'd232;
  localparam logic [9:0] V_SYNC_B = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_LAST   = 10'd524;

  // Button bit order: 0 LEFT, 1 DOWN, 2 RIGHT, 3 UP, 4 ENTER, 5 DEBUG.
  logic [N_BTN-1:0] btn_raw;
  logic             debug_view;

`ifdef MAIN_GAME_DEBUG_EN
  assign btn_raw = {BTN_RAW_DEBUG, BTN_RAW_ENTER, BTN_RAW_UP,
                    BTN_RAW_RIGHT, BTN_RAW_DOWN, BTN_RAW_LEFT};
`else
  logic unused_debug;
  assign unused_debug = BTN_RAW_DEBUG;
  assign btn_raw = {BTN_RAW_ENTER, BTN_RAW_UP, BTN_RAW_RIGHT,
                    BTN_RAW_DOWN, BTN_RAW_LEFT};
`endif

  logic [N_BTN-1:0] sync1, sync2, db_level;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [4:0]       press;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      press    <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // The counter only runs while the synchronised level disagrees with the
      // accepted one; any agreeing sample restarts the stability window.
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      // One-cycle pulse on an accepted 0->1 transition.
      for (int i = 0; i < 5; i++)
        press[i] <= sync2[i] & ~db_level[i] & (db_cnt[i] == DB_LAST);
    end
  end

`ifdef MAIN_GAME_DEBUG_EN
  assign debug_view = db_level[5];
`else
  assign debug_view = 1'b0;
`endif

  // Fixed priority ENTER > UP > DOWN > LEFT > RIGHT; losers are dropped.
  logic do_enter, do_up, do_down, do_left, do_right;
  assign do_enter = press[4];
  assign do_up    = press[3] & ~press[4];
  assign do_down  = press[1] & ~(press[4] | press[3]);
  assign do_left  = press[0] & ~(press[4] | press[3] | press[1]);
  assign do_right = press[2] & ~(press[4] | press[3] | press[1] | press[0]);

  // x^16+x^14+x^13+x^11+1, shifting towards the MSB.
  logic [15:0] lfsr;
  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  function automatic logic [2:0] mod6(input logic [2:0] v);
    return (v >= 3'd6) ? v - 3'd6 : v;
  endfunction

  function automatic logic [2:0] colour_rgb(input logic [2:0] c);
    case (c)
      3'd0:    return 3'b011;
      3'd1:    return 3'b100;
      3'd2:    return 3'b010;
      3'd3:    return 3'b001;
      3'd4:    return 3'b110;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0]      state;
  logic [2:0]      secret [4];
  logic [2:0]      guess  [4];
  logic [1:0]      cursor;
  logic [GC_W-1:0] gcnt;
  logic [2:0]      exact_q, white_q;

  // Scoring: exact position matches, and colour matches regardless of position.
  logic [2:0] exact_c, total_c, cnt_s, cnt_g;
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    exact_c = '0;
    total_c = '0;
    cnt_s   = '0;
    cnt_g   = '0;
    for (int i = 0; i < 4; i++)
      if (guess[i] == secret[i]) exact_c = exact_c + 3'd1;
    for (int c = 0; c < 6; c++) begin
      cnt_s = '0;
      cnt_g = '0;
      for (int i = 0; i < 4; i++) begin
        if (secret[i] == 3'(c)) cnt_s = cnt_s + 3'd1;
        if (guess[i]  == 3'(c)) cnt_g = cnt_g + 3'd1;
      end
      total_c = total_c + ((cnt_s < cnt_g) ? cnt_s : cnt_g);
    end
  end

  logic [GC_W-1:0] gcnt_next;
  assign gcnt_next = gcnt + 1'b1;

  // NOTE: secret/guess are a few flops, not a RAM, so they take the async
  // reset like every other register and nothing survives a mid-game reset.
  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      cursor  <= '0;
      gcnt    <= '0;
      exact_q <= '0;
      white_q <= '0;
      for (int i = 0; i < 4; i++) begin
        secret[i] <= '0;
        guess[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (do_enter) state <= S_GEN;
        S_GEN: begin
          for (int i = 0; i < 4; i++) begin
            secret[i] <= mod6(lfsr[3*i +: 3]);
            guess[i]  <= '0;
          end
          cursor  <= '0;
          gcnt    <= '0;
          exact_q <= '0;
          white_q <= '0;
          state   <= S_PLAY;
        end
        S_PLAY: begin
          if (do_enter)      state <= S_CHECK;
          else if (do_up)    guess[cursor] <= (guess[cursor] == 3'd5) ? 3'd0 : guess[cursor] + 3'd1;
          else if (do_down)  guess[cursor] <= (guess[cursor] == 3'd0) ? 3'd5 : guess[cursor] - 3'd1;
          else if (do_left)  cursor <= cursor - 2'd1;
          else if (do_right) cursor <= cursor + 2'd1;
        end
        S_CHECK: begin
          exact_q <= exact_c;
          white_q <= total_c - exact_c;
          gcnt    <= gcnt_next;
          if (exact_c == 3'd4)          state <= S_WIN;
          else if (gcnt_next == GC_MAX) state <= S_LOSE;
          else                          state <= S_PLAY;
        end
        S_WIN, S_LOSE: if (do_enter) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [3:0] led_vec;
  always_comb begin
    led_vec = 4'b0000;
    if (state == S_WIN) begin
      led_vec = 4'b1111;
    end else if (state == S_PLAY || state == S_CHECK) begin
      case (exact_q)
        3'd0:    led_vec = 4'b0000;
        3'd1:    led_vec = 4'b0001;
        3'd2:    led_vec = 4'b0011;
        3'd3:    led_vec = 4'b0111;
        default: led_vec = 4'b1111;
      endcase
    end
  end
  assign {LED3, LED2, LED1, LED0} = led_vec;

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt;
  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign VGA_HSYNC = !(h_cnt >= H_SYNC_B && h_cnt <= H_SYNC_E);
  assign VGA_VSYNC = !(v_cnt >= V_SYNC_B && v_cnt <= V_SYNC_E);

  // Screen split into four 160-pixel columns, one per code slot.
  logic [1:0] band;
  logic [2:0] total_q, rgb;
  assign band    = (h_cnt >= 10'd480) ? 2'd3 : (h_cnt >= 10'd320) ? 2'd2 :
                   (h_cnt >= 10'd160) ? 2'd1 : 2'd0;
  assign total_q = exact_q + white_q;

  always_comb begin
    rgb = 3'b000;
    if (state != S_IDLE && h_cnt < H_ACTIVE && v_cnt < V_ACTIVE) begin
      if (v_cnt < V_SPLIT) begin
        if (v_cnt >= V_CURSOR && band == cursor) rgb = 3'b111;
        else                                      rgb = colour_rgb(guess[band]);
      end else if (state == S_WIN) begin
        rgb = 3'b010;
      end else if (state == S_LOSE || (state == S_PLAY && debug_view)) begin
        rgb = colour_rgb(secret[band]);
      end else if ({1'b0, band} < exact_q) begin
        rgb = 3'b100;
      end else if ({1'b0, band} < total_q) begin
        rgb = 3'b111;
      end
    end
  end
  assign {VGA_R, VGA_G, VGA_B} = rgb;

endmodule

// File: tb/tb_main_game.sv
// Self-checking bench for main_game: random button play scored by a
// game-level reference model; LEDs, upper-band pixels and sync timing are
// compared against values the model derives from elapsed cycles and the rules.
module tb_main_game;

  localparam int DB   = 16;
  localparam int MAXG = 10;
  localparam int PD   = 2;

  localparam logic [5:0] B_LEFT  = 6'b000001;
  localparam logic [5:0] B_DOWN  = 6'b000010;
  localparam logic [5:0] B_RIGHT = 6'b000100;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_ENTER = 6'b010000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] raw = '0;
  logic       led0, led1, led2, led3, vga_r, vga_g, vga_b, hsync, vsync;
  logic [3:0] leds;
  logic [2:0] rgb;

  assign leds = {led3, led2, led1, led0};
  assign rgb  = {vga_r, vga_g, vga_b};

  main_game #(.DEBOUNCE_CYCLES(DB), .MAX_GUESSES(MAXG), .PIX_DIV(PD)) dut (
    .CLK0(clk), .RST_N(rst_n),
    .BTN_RAW_LEFT(raw[0]), .BTN_RAW_DOWN(raw[1]), .BTN_RAW_RIGHT(raw[2]),
    .BTN_RAW_UP(raw[3]), .BTN_RAW_ENTER(raw[4]), .BTN_RAW_DEBUG(raw[5]),
    .LED0(led0), .LED1(led1), .LED2(led2), .LED3(led3),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HSYNC(hsync), .VGA_VSYNC(vsync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Elapsed edges since reset and the LFSR value they imply
  // (taps 16,14,13,11 -> bits 15,13,12,10, shifting up from seed ACE1).
  int          k;
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      k      <= k + 1;
      m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end
  end

  // Game-level model: only the settled states a player can observe.
  typedef enum {M_IDLE, M_PLAY, M_WIN, M_LOSE} mstate_t;
  mstate_t st = M_IDLE;
  int secret[4], guess[4], target[4];
  int cursor, gcnt, m_exact, m_total;
  int cmap[6] = '{3, 4, 2, 1, 6, 5};

  function automatic int exp_leds();
    if (st == M_WIN)  return 15;
    if (st == M_PLAY) return (1 << m_exact) - 1;
    return 0;
  endfunction

  function automatic int exp_rgb(input int h, input int v);
    int j;
    if (st == M_IDLE || h >= 640 || v >= 480) return 0;
    j = h / 160;
    if (v < 240) return (v >= 232 && j == cursor) ? 7 : cmap[guess[j]];
    if (st == M_WIN)  return 2;
    if (st == M_LOSE) return cmap[secret[j]];
    if (j < m_exact)  return 4;
    if (j < m_total)  return 7;
    return 0;
  endfunction

  function automatic bit guess_is_secret();
    for (int i = 0; i < 4; i++) if (guess[i] != secret[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    st = M_IDLE; cursor = 0; gcnt = 0; m_exact = 0; m_total = 0;
    for (int i = 0; i < 4; i++) begin secret[i] = 0; guess[i] = 0; end
  endtask

  task automatic model_apply(input logic [5:0] mask, input logic [15:0] snap);
    int cs[6], cg[6];
    if (mask[4]) begin
      case (st)
        M_IDLE: begin
          for (int i = 0; i < 4; i++) begin
            secret[i] = ((snap >> (3 * i)) & 7) % 6;
            guess[i]  = 0;
          end
          cursor = 0; gcnt = 0; m_exact = 0; m_total = 0; st = M_PLAY;
        end
        M_PLAY: begin
          m_exact = 0; m_total = 0;
          for (int c = 0; c < 6; c++) begin cs[c] = 0; cg[c] = 0; end
          for (int i = 0; i < 4; i++) begin
            if (guess[i] == secret[i]) m_exact++;
            cs[secret[i]]++;
            cg[guess[i]]++;
          end
          for (int c = 0; c < 6; c++) m_total += (cs[c] < cg[c]) ? cs[c] : cg[c];
          gcnt++;
          if (m_exact == 4)     st = M_WIN;
          else if (gcnt == MAXG) st = M_LOSE;
        end
        default: st = M_IDLE;
      endcase
    end else if (st == M_PLAY) begin
      if (mask[3])      guess[cursor] = (guess[cursor] + 1) % 6;
      else if (mask[1]) guess[cursor] = (guess[cursor] + 5) % 6;
      else if (mask[0]) cursor = (cursor + 3) % 4;
      else if (mask[2]) cursor = (cursor + 1) % 4;
    end
  endtask

  // Hold the buttons for 'hold' cycles, release and let them settle. A level
  // held for at least DB cycles is accepted; GEN then samples the LFSR value
  // present DB+3 edges after the press was driven.
  task automatic press(input logic [5:0] mask, input int hold);
    logic [15:0] snap = '0;
    @(posedge clk); #1;
    raw = mask;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (i == DB + 3) snap = m_lfsr;
    end
    raw = '0;
    repeat (DB + 6) @(posedge clk);
    #1;
    if (hold >= DB + 3) model_apply(mask, snap);
  endtask

  task automatic tap(input logic [5:0] mask);
    press(mask, DB + 4);
  endtask

  // Scan one full line and compare the centre of each column plus blanking.
  task automatic scan_line(input string tag);
    int h, v;
    for (int c = 0; c < 800 * PD; c++) begin
      @(negedge clk);
      h = (k / PD) % 800;
      v = (k / PD) / 800 % 525;
      if ((h < 640 && h % 160 == 80) || h == 700)
        check($sformatf("%s_rgb_h%0d", tag, h), int'(rgb), exp_rgb(h, v));
    end
  endtask

  task automatic random_moves(input int n);
    logic [5:0] mask;
    for (int i = 0; i < n; i++) begin
      mask = 6'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) mask |= 6'(1 << $urandom_range(0, 3));
      tap(mask);
    end
  endtask

  task automatic set_guess();
    for (int p = 0; p < 4; p++) begin
      while (cursor != p) tap(B_RIGHT);
      while (guess[p] != target[p]) tap(B_UP);
    end
  endtask

  task automatic wrong_guess(input string tag);
    if (guess_is_secret()) tap(B_UP);
    tap(B_ENTER);
    check({tag, "_leds"}, int'(leds), exp_leds());
  endtask

  // Sync boundaries, checked continuously against the elapsed-cycle model.
  int mh, mv;
  always @(negedge clk) begin
    if (rst_n) begin
      mh = (k / PD) % 800;
      mv = (k / PD) / 800 % 525;
      if (mh == 655 || mh == 656 || mh == 751 || mh == 752)
        check($sformatf("hsync_h%0d", mh), int'(hsync), (mh >= 656 && mh <= 751) ? 0 : 1);
      if (mh == 0)
        check("vsync", int'(vsync), (mv == 490 || mv == 491) ? 0 : 1);
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: cycle budget exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check_in_reset(input string tag);
    check({tag, "_leds"},  int'(leds),  0);
    check({tag, "_rgb"},   int'(rgb),   0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
  endtask

  initial begin
    int t0, t1;
    logic prev;

    model_reset();
    repeat (3) @(posedge clk);
    #1 check_in_reset("rst");
    @(negedge clk) rst_n = 1'b1;

    // Idle: nothing lit, screen black, HSYNC period of 800 pixels.
    repeat (5000) @(negedge clk);
    check("idle_leds", int'(leds), exp_leds());
    scan_line("idle");
    t0 = -1; t1 = -1; prev = hsync;
    for (int c = 0; c < 4000 && t1 < 0; c++) begin
      @(negedge clk);
      if (prev && !hsync) begin
        if (t0 < 0) t0 = k;
        else        t1 = k;
      end
      prev = hsync;
    end
    check("hsync_period", t1 - t0, 800 * PD);

    // Game 1: long ENTER gives a single press; boundaries; priority; win.
    press(B_ENTER, 50);
    check("gen_leds", int'(leds), exp_leds());
    scan_line("gen");
    press(B_UP, DB - 2);
    scan_line("bounce");
    tap(B_LEFT);
    tap(B_UP);
    scan_line("cursor_wrap");
    tap(B_RIGHT);
    tap(B_DOWN);
    tap(B_UP);
    scan_line("colour_wrap");
    tap(B_RIGHT | B_LEFT);
    tap(B_UP | B_DOWN);
    scan_line("prio_moves");
    for (int g = 0; g < 3; g++) begin
      random_moves($urandom_range(2, 5));
      wrong_guess($sformatf("g1_guess%0d", g));
    end
    if (guess_is_secret()) tap(B_DOWN);
    tap(B_ENTER | B_UP);
    check("prio_enter_leds", int'(leds), exp_leds());
    scan_line("g1_play");
    for (int i = 0; i < 4; i++) target[i] = secret[i];
    set_guess();
    tap(B_ENTER);
    check("win_leds", int'(leds), exp_leds());
    scan_line("win");
    tap(B_ENTER);
    check("win_idle_leds", int'(leds), exp_leds());
    scan_line("win_idle");

    // Game 2: ten wrong guesses, the first three with 1..3 exact matches.
    tap(B_ENTER);
    for (int g = 0; g < MAXG; g++) begin
      if (g < 3) begin
        for (int i = 0; i < 4; i++) target[i] = (i <= g) ? secret[i] : (secret[i] + 1) % 6;
        set_guess();
      end else begin
        random_moves($urandom_range(1, 4));
      end
      wrong_guess($sformatf("g2_guess%0d", g));
    end
    scan_line("lose");
    tap(B_ENTER);
    check("lose_idle_leds", int'(leds), exp_leds());
    scan_line("lose_idle");

    // Game 3: reset mid-game, then the fresh LFSR run must still be modelled.
    tap(B_ENTER);
    random_moves(3);
    tap(B_ENTER);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_in_reset("midrst");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    scan_line("midrst_idle");
    tap(B_ENTER);
    check("g3_gen_leds", int'(leds), exp_leds());
    for (int i = 0; i < 4; i++) target[i] = secret[i];
    set_guess();
    tap(B_ENTER);
    check("g3_win_leds", int'(leds), exp_leds());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/main_game.md
MAIN_GAME -- requirements
Module: main_game

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, clock cycles a raw button level must stay stable before acceptance.
REQ-002 Parameter MAX_GUESSES, default 10, guesses allowed before loss.
REQ-003 Parameter PIX_DIV, default 2, clock cycles per VGA pixel.
REQ-004 CLK0  input  1  system clock; all logic is on its rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 BTN_RAW_LEFT, BTN_RAW_DOWN, BTN_RAW_RIGHT, BTN_RAW_UP, BTN_RAW_ENTER, BTN_RAW_DEBUG  input  1 each  raw asynchronous push buttons, active-high.
REQ-007 LED0..LED3  output  1 each  hint/status LEDs.
REQ-008 VGA_R, VGA_G, VGA_B  output  1 each  pixel colour.
REQ-009 VGA_HSYNC, VGA_VSYNC  output  1 each  sync pulses, active-low.

Function
REQ-010 Each button: 2-FF synchroniser, then a debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive equal samples; an accepted 0->1 transition produces a one-cycle press pulse.
REQ-011 At most one press acts per cycle, with priority ENTER > UP > DOWN > LEFT > RIGHT; lower-priority pulses in that cycle are dropped.
REQ-012 A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, nonzero seed 16'hACE1) runs every cycle from reset.
REQ-013 States: IDLE, GEN, PLAY, CHECK, WIN, LOSE; reset enters IDLE.
REQ-014 IDLE: on an ENTER press, go to GEN.
REQ-015 GEN (one cycle): latch secret[0..3] = (LFSR[3i+2:3i] mod 6), clear guess to 0, clear cursor to 0, clear guess counter, clear hints, then go to PLAY.
REQ-016 PLAY: LEFT/RIGHT decrements/increments cursor 0..3 with wrap; UP/DOWN increments/decrements guess[cursor] in range 0..5 with wrap; ENTER goes to CHECK.
REQ-017 CHECK (one cycle): exact = count of i with guess[i]==secret[i]; total = sum over colours c of min(count_c(secret), count_c(guess)); white = total - exact; register both and increment the guess counter.
REQ-018 CHECK exit: exact==4 goes to WIN; else if counter==MAX_GUESSES goes to LOSE; else goes to PLAY (guess retained).
REQ-019 WIN/LOSE: an ENTER press goes to IDLE.
REQ-020 LEDs in PLAY/CHECK: LEDk = (k < exact). WIN: all LEDs 1. LOSE and IDLE: all LEDs 0.
REQ-021 VGA timing: 640x480, horizontal total 800 with HSYNC low for counts 656..751; vertical total 525 with VSYNC low for lines 490..491; counters advance once per PIX_DIV clocks.
REQ-022 RGB is 0 outside the active area and in IDLE.
REQ-023 Colour map: 0=GB, 1=R, 2=G, 3=B, 4=RG, 5=RB.
REQ-024 Active rows 0..239: column band x/160 shows guess[x/160]; rows 232..239 under the cursor slot show white (RGB=111).
REQ-025 Active rows 240..479: square j=x/160 is red if j<exact, white if exact<=j<total, else black.
REQ-026 Lower band override: WIN shows all green; LOSE shows secret colours.
REQ-027 A reset asserted mid-game aborts immediately; no state survives.

Reset
REQ-028 While RST_N=0: state=IDLE, LFSR=seed, secret, guess, cursor, counter and hints = 0, debouncers idle at 0, VGA counters = 0, LEDs = 0, RGB = 0, HSYNC=VSYNC=1.

Configuration
REQ-029 Macro MAIN_GAME_DEBUG_EN defined: in PLAY, while debounced BTN_RAW_DEBUG=1, the lower band shows the secret colours instead of hints.
REQ-030 Macro MAIN_GAME_DEBUG_EN undefined: BTN_RAW_DEBUG is ignored and its debouncer is not built.

Verification
REQ-031 Reset, then idle for 5000 cycles -> LEDs 0, RGB 0, HSYNC period 800*PIX_DIV clocks, VSYNC period 525 lines.
REQ-032 Hold ENTER for 50 cycles -> exactly one press pulse; state passes GEN to PLAY; every secret digit is <=5.
REQ-033 With secret forced to {1,2,3,4}, guess {1,3,2,0} -> exact=1, white=2, LED0=1, LED1..3=0.
REQ-034 Guess equal to secret -> WIN, all LEDs 1; an ENTER press then returns to IDLE.
REQ-035 Ten wrong guesses -> LOSE after the tenth CHECK; lower band shows the secret.
REQ-036 Cursor at 3 plus RIGHT -> cursor 0; colour 5 plus UP -> 0; a bounce shorter than DEBOUNCE_CYCLES -> no action.
